cache_refill_controller: RTL and testbench

Sequences a cache line refill after a lookup miss in the set-associative instruction/data cache. It asks the replacement policy for a victim way in the missed set, invalidates that line, bursts the line in word by word from the memory port, writes the data and tag arrays, then signals completion. One refill is in flight at a time. The block sits between the cache lookup stage, the replacement policy, the tag/data arrays and the memory-side request/grant/rvalid port.

---
 rtl/cache_refill_controller.sv | 168 ++++++++++++++++
 tb/tb_cache_refill_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_controller.sv
// Cache line refill sequencer: picks a victim way, invalidates it, bursts the line in
// from memory one word per request, then writes the tag with valid set and pulses fill_done.
module cache_refill_controller #(
  parameter int WAY_COUNT      = 2,
  parameter int SET_COUNT      = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32,
  localparam int IDX   = $clog2(SET_COUNT),
  localparam int WOFF  = $clog2(WORDS_PER_LINE),
  localparam int TAG   = ADDR_WIDTH - IDX - WOFF - 2,
  localparam int WAYW  = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  miss_valid_i,
  input  logic [ADDR_WIDTH-1:0] miss_addr_i,
  output logic                  miss_ready_o,
  output logic [IDX-1:0]        rp_set_o,
  input  logic [WAYW-1:0]       rp_way_i,
  input  logic                  rp_ready_i,
  output logic                  rp_taken_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  dw_en_o,
  output logic [IDX-1:0]        dw_set_o,
  output logic [WAYW-1:0]       dw_way_o,
  output logic [WOFF-1:0]       dw_word_o,
  output logic [31:0]           dw_data_o,
  output logic                  tw_en_o,
  output logic [IDX-1:0]        tw_set_o,
  output logic [WAYW-1:0]       tw_way_o,
  output logic [TAG-1:0]        tw_tag_o,
  output logic                  tw_valid_o,
  output logic                  fill_done_o
);

  localparam int LINEW = TAG + IDX;
  localparam logic [WOFF-1:0] LAST_WORD = WOFF'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VICTIM = 3'd1,
    S_REQ    = 3'd2,
    S_WAIT   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [LINEW-1:0] line_q, line_d;
  logic [WAYW-1:0]  way_q, way_d;
  logic [WOFF-1:0]  cnt_q, cnt_d;

  logic            miss_ready_s, rp_taken_s, mem_req_s, dw_en_s;
  logic            tw_en_s, tw_valid_s, fill_done_s;
  logic [WAYW-1:0] tw_way_s;

  // Word and byte offsets of the miss never reach memory: refills always start at the line base.
  logic unused_s;
  assign unused_s = ^miss_addr_i[WOFF+1:0];

  // State and latched refill context.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    way_d        = way_q;
    cnt_d        = cnt_q;
    miss_ready_s = 1'b0;
    rp_taken_s   = 1'b0;
    mem_req_s    = 1'b0;
    dw_en_s      = 1'b0;
    tw_en_s      = 1'b0;
    tw_valid_s   = 1'b0;
    fill_done_s  = 1'b0;
    tw_way_s     = way_q;
    case (state_q)
      S_IDLE: begin
        miss_ready_s = 1'b1;
        if (miss_valid_i) begin
          line_d  = miss_addr_i[ADDR_WIDTH-1:WOFF+2];
          cnt_d   = '0;
          state_d = S_VICTIM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VICTIM: begin
        // The victim is invalidated before any word lands, so an aborted refill leaves it invalid.
        if (rp_ready_i) begin
          way_d      = rp_way_i;
          rp_taken_s = 1'b1;
          tw_en_s    = 1'b1;
          tw_way_s   = rp_way_i;
          state_d    = S_REQ;
        end else begin
          state_d = S_VICTIM;
        end
      end
      S_REQ: begin
        mem_req_s = 1'b1;
        if (mem_gnt_i) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          dw_en_s = 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d = S_COMMIT;
          end else begin
            cnt_d   = cnt_q + WOFF'(1);
            state_d = S_REQ;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_COMMIT: begin
        tw_en_s     = 1'b1;
        tw_valid_s  = 1'b1;
        fill_done_s = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are held low while reset is asserted so an aborted refill issues no writes.
  assign miss_ready_o = miss_ready_s & ~reset_i;
  assign rp_taken_o   = rp_taken_s   & ~reset_i;
  assign mem_req_o    = mem_req_s    & ~reset_i;
  assign dw_en_o      = dw_en_s      & ~reset_i;
  assign tw_en_o      = tw_en_s      & ~reset_i;
  assign tw_valid_o   = tw_valid_s   & ~reset_i;
  assign fill_done_o  = fill_done_s  & ~reset_i;

  assign rp_set_o   = line_q[IDX-1:0];
  assign mem_addr_o = {line_q, cnt_q, 2'b00};
  assign dw_set_o   = line_q[IDX-1:0];
  assign dw_way_o   = way_q;
  assign dw_word_o  = cnt_q;
  assign dw_data_o  = mem_rdata_i;
  assign tw_set_o   = line_q[IDX-1:0];
  assign tw_way_o   = tw_way_s;
  assign tw_tag_o   = line_q[LINEW-1:IDX];

endmodule

// File: tb/tb_cache_refill_controller.sv
// Bench for cache_refill_controller: acts as policy and memory, derives expected
// addresses, fields and latency from address arithmetic, and tallies strobes.
module tb_cache_refill_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic [5:0]  rp_set;
  logic [0:0]  rp_way;
  logic        rp_ready;
  logic        rp_taken;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        dw_en;
  logic [5:0]  dw_set;
  logic [0:0]  dw_way;
  logic [1:0]  dw_word;
  logic [31:0] dw_data;
  logic        tw_en;
  logic [5:0]  tw_set;
  logic [0:0]  tw_way;
  logic [21:0] tw_tag;
  logic        tw_valid;
  logic        fill_done;

  cache_refill_controller dut (
    .clk_i(clk), .reset_i(reset),
    .miss_valid_i(miss_valid), .miss_addr_i(miss_addr), .miss_ready_o(miss_ready),
    .rp_set_o(rp_set), .rp_way_i(rp_way), .rp_ready_i(rp_ready), .rp_taken_o(rp_taken),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .dw_en_o(dw_en), .dw_set_o(dw_set), .dw_way_o(dw_way), .dw_word_o(dw_word), .dw_data_o(dw_data),
    .tw_en_o(tw_en), .tw_set_o(tw_set), .tw_way_o(tw_way), .tw_tag_o(tw_tag), .tw_valid_o(tw_valid),
    .fill_done_o(fill_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0, n_fail = 0;
  int n_rp = 0, n_inval = 0, n_valid = 0, n_fill = 0, n_dw = 0;
  int exp_rp = 0, exp_valid = 0, exp_dw = 0;
  int gw[4], rw[4];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe tally, sampled mid-low-phase once inputs and outputs have settled.
  always @(negedge clk) begin
    #2;
    if (rp_taken)             n_rp    <= n_rp + 1;
    if (tw_en && !tw_valid)   n_inval <= n_inval + 1;
    if (tw_en && tw_valid)    n_valid <= n_valid + 1;
    if (fill_done)            n_fill  <= n_fill + 1;
    if (dw_en)                n_dw    <= n_dw + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One refill as seen by the requester, policy and memory. abort_word >= 0 applies
  // reset in the WAIT phase of that word instead of returning data.
  task automatic do_refill(input logic [31:0] addr, input logic [0:0] way, input int stall,
                           input bit hold, input logic [31:0] next_addr, input int abort_word);
    logic [31:0] set_e, tag_e, base, d;
    int acc, extra;
    set_e = (addr >> 4) & 32'h3F;
    tag_e = addr >> 10;
    base  = addr & ~32'hF;
    extra = stall;

    miss_valid = 1'b1;
    miss_addr  = addr;
    #1;
    check_eq("accept_ready", 64'(miss_ready), 64'd1);
    acc = cyc;
    @(negedge clk);
    if (hold) miss_addr = next_addr;
    else      miss_valid = 1'b0;

    for (int i = 0; i < stall; i++) begin
      rp_ready = 1'b0;
      rp_way   = 1'($urandom);
      #1;
      check_eq("stall_no_taken", 64'(rp_taken), 64'd0);
      check_eq("stall_no_req", 64'(mem_req), 64'd0);
      @(negedge clk);
    end

    rp_ready = 1'b1;
    rp_way   = way;
    #1;
    check_eq("rp_set", 64'(rp_set), 64'(set_e));
    check_eq("rp_taken", 64'(rp_taken), 64'd1);
    check_eq("inval_en", 64'(tw_en), 64'd1);
    check_eq("inval_valid", 64'(tw_valid), 64'd0);
    check_eq("inval_set", 64'(tw_set), 64'(set_e));
    check_eq("inval_way", 64'(tw_way), 64'(way));
    check_eq("busy_not_ready", 64'(miss_ready), 64'd0);
    exp_rp++;
    @(negedge clk);
    rp_ready = 1'b0;
    rp_way   = 1'($urandom);

    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g <= gw[k]; g++) begin
        mem_gnt = (g == gw[k]);
        #1;
        check_eq("mem_req", 64'(mem_req), 64'd1);
        check_eq("mem_addr", 64'(mem_addr), 64'(base + 32'(k * 4)));
        @(negedge clk);
      end
      mem_gnt = 1'b0;

      if (k == abort_word) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("abort_idle", 64'(miss_ready), 64'd1);
        check_eq("abort_req", 64'(mem_req), 64'd0);
        check_eq("abort_tw_en", 64'(tw_en), 64'd0);
        check_eq("abort_done", 64'(fill_done), 64'd0);
        check_eq("abort_dw_en", 64'(dw_en), 64'd0);
        return;
      end

      for (int r = 0; r <= rw[k]; r++) begin
        if (r == rw[k]) begin
          d          = $urandom;
          mem_rvalid = 1'b1;
          mem_rdata  = d;
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
          mem_gnt    = 1'($urandom_range(0, 1));
        end
        #1;
        if (r == rw[k]) begin
          check_eq("dw_en", 64'(dw_en), 64'd1);
          check_eq("dw_set", 64'(dw_set), 64'(set_e));
          check_eq("dw_way", 64'(dw_way), 64'(way));
          check_eq("dw_word", 64'(dw_word), 64'(k));
          check_eq("dw_data", 64'(dw_data), 64'(d));
          exp_dw++;
        end else begin
          check_eq("wait_no_dw", 64'(dw_en), 64'd0);
          check_eq("wait_no_req", 64'(mem_req), 64'd0);
        end
        @(negedge clk);
        mem_gnt = 1'b0;
      end
      mem_rvalid = 1'b0;
      extra += gw[k] + rw[k];
    end

    #1;
    check_eq("fill_done", 64'(fill_done), 64'd1);
    check_eq("commit_en", 64'(tw_en), 64'd1);
    check_eq("commit_valid", 64'(tw_valid), 64'd1);
    check_eq("commit_tag", 64'(tw_tag), 64'(tag_e));
    check_eq("commit_set", 64'(tw_set), 64'(set_e));
    check_eq("commit_way", 64'(tw_way), 64'(way));
    check_eq("commit_busy", 64'(miss_ready), 64'd0);
    check_eq("latency", 64'(cyc - acc), 64'(10 + extra));
    exp_valid++;
    @(negedge clk);
    #1;
    check_eq("done_pulse_end", 64'(fill_done), 64'd0);
    check_eq("back_idle", 64'(miss_ready), 64'd1);
  endtask

  task automatic set_waits(input int g0, input int g1, input int g2, input int g3,
                           input int r0, input int r1, input int r2, input int r3);
    gw[0] = g0; gw[1] = g1; gw[2] = g2; gw[3] = g3;
    rw[0] = r0; rw[1] = r1; rw[2] = r2; rw[3] = r3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; miss_valid = 1'b0; miss_addr = 32'd0; rp_way = 1'b0; rp_ready = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_ready", 64'(miss_ready), 64'd1);
    check_eq("rst_req", 64'(mem_req), 64'd0);
    check_eq("rst_taken", 64'(rp_taken), 64'd0);
    check_eq("rst_tw_en", 64'(tw_en), 64'd0);
    check_eq("rst_dw_en", 64'(dw_en), 64'd0);
    check_eq("rst_done", 64'(fill_done), 64'd0);
    check_eq("rst_set", 64'(rp_set), 64'd0);
    check_eq("rst_addr", 64'(mem_addr), 64'd0);

    // Stray memory handshakes while idle.
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; mem_gnt = 1'b1;
    #1;
    check_eq("spur_dw_en", 64'(dw_en), 64'd0);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    #1;
    check_eq("spur_idle", 64'(miss_ready), 64'd1);
    check_eq("spur_req", 64'(mem_req), 64'd0);
    @(negedge clk);

    set_waits(0, 0, 0, 0, 0, 0, 0, 0);
    do_refill(32'h0000_1234, 1'b1, 0, 1'b0, 32'd0, -1);
    do_refill(32'h0000_5678, 1'b0, 5, 1'b0, 32'd0, -1);
    set_waits(0, 0, 3, 0, 0, 0, 0, 0);
    do_refill(32'h0000_1234, 1'b0, 0, 1'b0, 32'd0, -1);

    set_waits(0, 0, 0, 0, 0, 0, 0, 0);
    do_refill(32'h0000_1234, 1'b1, 0, 1'b1, 32'h0000_2040, -1);
    do_refill(32'h0000_2040, 1'b0, 0, 1'b0, 32'd0, -1);

    set_waits(0, 1, 0, 0, 0, 1, 0, 0);
    do_refill(32'h0000_3000, 1'b1, 1, 1'b0, 32'd0, 1);
    set_waits(0, 0, 0, 0, 0, 0, 0, 0);
    do_refill(32'h0000_3000, 1'b0, 0, 1'b0, 32'd0, -1);

    for (int t = 0; t < 16; t++) begin
      for (int k = 0; k < 4; k++) begin
        gw[k] = $urandom_range(0, 2);
        rw[k] = $urandom_range(0, 2);
      end
      do_refill($urandom, 1'($urandom), $urandom_range(0, 3), 1'b0, 32'd0, -1);
    end

    repeat (3) @(negedge clk);
    #3;
    check_eq("cnt_rp_taken", 64'(n_rp), 64'(exp_rp));
    check_eq("cnt_inval", 64'(n_inval), 64'(exp_rp));
    check_eq("cnt_valid_wr", 64'(n_valid), 64'(exp_valid));
    check_eq("cnt_fill_done", 64'(n_fill), 64'(exp_valid));
    check_eq("cnt_dw", 64'(n_dw), 64'(exp_dw));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
